// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared types and helpers for the rv datapath memory path:
//               access-size encoding, mem_port FSM states, load extension.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  // Access size as carried on the size bus; 2'b11 is reserved
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  // mem_port transaction sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } mem_state_e;

  // Number of bytes touched minus one; reserved size reports 0
  function automatic logic [1:0] size_span(input logic [1:0] size);
    logic [1:0] span;
    case (size)
      MEM_H:   span = 2'd1;
      MEM_W:   span = 2'd3;
      default: span = 2'd0;
    endcase
    return span;
  endfunction

  // Right-justify the addressed lane(s) of an aligned word, then extend
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      MEM_H:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_if
// Description : Request/acknowledge bus between a requester and mem_port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (output req, we, size, uns, addr, wdata,
                  input  rdata, ack, err, busy);
  modport slave  (input  req, we, size, uns, addr, wdata,
                  output rdata, ack, err, busy);
endinterface
`default_nettype wire

// File: rtl/mem_port_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Word-organised byte-lane storage, per-lane write enables,
//               registered 32-bit read. No reset: contents survive rst.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
  parameter int DEPTH_BYTES = 4096,
  parameter int IW          = 10
) (
  input  logic          clk,
  input  logic [IW-1:0] idx_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);
  localparam int WORDS = DEPTH_BYTES / 4;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem_q [WORDS];
    logic [7:0] rd_q;

    // One byte lane: write when enabled, capture read data when requested
    always_ff @(posedge clk) begin
      if (we_i[i]) mem_q[idx_i] <= wdata_i[8*i +: 8];
      if (re_i)    rd_q         <= mem_q[idx_i];
    end

    assign rdata_o[8*i +: 8] = rd_q;
  end
endmodule
`default_nettype wire

// File: rtl/mem_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_port
// Description : Byte-addressed data memory with req/ack handshake, optional
//               wait states, B/H/W accesses with sign/zero extension and
//               misalignment / range error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port
  import rv_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic     clk,
  input  logic     rst,
  mem_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int IW = (AW > 2) ? AW - 2 : 1;
  localparam logic [3:0]      CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH_BYTES);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              enter_resp;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, hold_q;

  logic              idle, t_we, t_err;
  logic [1:0]        t_size;
  logic [ADDR_W-1:0] t_addr;
  logic [31:0]       t_wdata, lane_wdata, arr_rd, rdata_w;
  logic [ADDR_W:0]   t_last;
  logic [3:0]        be, arr_we;
  logic              arr_re;

  // In IDLE the live bus is the transaction (zero-wait case writes at accept);
  // afterwards the latched copy is authoritative.
  assign idle    = (state_q == ST_IDLE);
  assign t_we    = idle ? bus.we    : we_q;
  assign t_size  = idle ? bus.size  : size_q;
  assign t_addr  = idle ? bus.addr  : addr_q;
  assign t_wdata = idle ? bus.wdata : wdata_q;

  // Range test on the full address width plus a carry bit, so no wrap-around
  assign t_last = {1'b0, t_addr} + {{(ADDR_W-1){1'b0}}, size_span(t_size)};
  assign t_err  = (t_size == 2'b11)
               || (t_size == MEM_H && t_addr[0])
               || (t_size == MEM_W && t_addr[1:0] != 2'b00)
               || (t_last >= DEPTH_L);

  // Little-endian lane enables and replicated store data
  always_comb begin
    be         = 4'b1111;
    lane_wdata = t_wdata;
    case (t_size)
      MEM_B: begin
        be         = 4'b0001 << t_addr[1:0];
        lane_wdata = {4{t_wdata[7:0]}};
      end
      MEM_H: begin
        be         = t_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{t_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Storage is touched only at the edge entering RESP and only for legal accesses
  assign arr_we = (enter_resp && t_we && !t_err && !rst) ? be : 4'b0000;
  assign arr_re = enter_resp && !t_we && !t_err;

  mem_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .IW          (IW)
  ) u_array (
    .clk     (clk),
    .idx_i   (t_addr[IW+1:2]),
    .we_i    (arr_we),
    .wdata_i (lane_wdata),
    .re_i    (arr_re),
    .rdata_o (arr_rd)
  );

  // Next-state and wait counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) err_q <= t_err;
    end
  end

  // Capture request fields when a transaction is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (idle && bus.req) begin
      we_q    <= bus.we;
      size_q  <= bus.size;
      uns_q   <= bus.uns;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  // Fresh load data shows only in a successful load's RESP cycle; otherwise hold
  assign rdata_w = (state_q == ST_RESP && !err_q && !we_q)
                 ? load_extend(arr_rd, size_q, uns_q, addr_q[1:0])
                 : hold_q;

  // Hold register keeps the last presented load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 32'h0;
    else     hold_q <= rdata_w;
  end

  assign bus.rdata = rdata_w;
  assign bus.ack   = (state_q == ST_RESP) && !err_q;
  assign bus.err   = (state_q == ST_RESP) &&  err_q;
  assign bus.busy  = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port
// Description : Self-checking bench for mem_port, zero and three wait states,
//               against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3;
  int   sel;
  logic req_v, we_v, uns_v;
  logic [1:0]  size_v;
  logic [31:0] addr_v, wdata_v;

  mem_port_if #(.ADDR_W(32)) if0 ();
  mem_port_if #(.ADDR_W(32)) if3 ();

  mem_port #(.DEPTH_BYTES(4096), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst0), .bus(if0.slave));
  mem_port #(.DEPTH_BYTES(4096), .ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(if3.slave));

  assign if0.req   = req_v && (sel == 0);
  assign if3.req   = req_v && (sel == 1);
  assign if0.we    = we_v;    assign if3.we    = we_v;
  assign if0.size  = size_v;  assign if3.size  = size_v;
  assign if0.uns   = uns_v;   assign if3.uns   = uns_v;
  assign if0.addr  = addr_v;  assign if3.addr  = addr_v;
  assign if0.wdata = wdata_v; assign if3.wdata = wdata_v;

  logic [31:0] o_rdata;
  logic [2:0]  o_flags;  // {busy, ack, err}
  assign o_rdata = (sel == 0) ? if0.rdata : if3.rdata;
  assign o_flags = (sel == 0) ? {if0.busy, if0.ack, if0.err} : {if3.busy, if3.ack, if3.err};

  int checks = 0;
  int errors = 0;
  logic [7:0]  mem_m [2][4096];
  logic [31:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_err(input logic [1:0] s, input logic [31:0] a);
    int n = nbytes(s);
    if (n == 0) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    return (longint'({32'h0, a}) + n) > 4096;
  endfunction

  function automatic logic [31:0] model_load(input int m, input logic [1:0] s,
                                             input logic u, input logic [31:0] a);
    int     n = nbytes(s);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(mem_m[m][a + k]) << (8 * k);
    if (!u && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v -= (64'sd1 <<< (8 * n));
    return v[31:0];
  endfunction

  // One transaction on the selected port; checks busy/ack/err timing and data
  task automatic txn(input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit toggle, input string tag);
    int          ws = (sel == 0) ? 0 : 3;
    bit          e  = model_err(s, a);
    logic [31:0] expv;
    @(negedge clk);
    req_v = 1'b1; we_v = w; size_v = s; uns_v = u; addr_v = a; wdata_v = d;
    for (int i = 0; i < ws; i++) begin
      @(negedge clk);
      chk({tag, "_wait"}, 32'(o_flags), 32'(3'b100));
      if (toggle) begin
        req_v = 1'($urandom); we_v = 1'($urandom); size_v = 2'($urandom);
        addr_v = $urandom; wdata_v = $urandom;
      end
    end
    @(negedge clk);
    expv = (e || w) ? exp_rd[sel] : model_load(sel, s, u, a);
    chk({tag, "_resp"}, 32'(o_flags), 32'({1'b1, !e, e}));
    chk({tag, "_rdata"}, o_rdata, expv);
    req_v = 1'b0;
    if (!e) begin
      if (w) for (int k = 0; k < nbytes(s); k++) mem_m[sel][a + k] = d[8*k +: 8];
      else   exp_rd[sel] = expv;
    end
    @(negedge clk);
    chk({tag, "_idle"}, 32'(o_flags), 32'(3'b000));
    chk({tag, "_hold"}, o_rdata, exp_rd[sel]);
  endtask

  function automatic logic [31:0] rand_addr(input int m);
    int r = $urandom_range(0, 9);
    if (r < 6)            return 32'($urandom_range(0, 63));
    if (r < 9 && m == 0)  return 32'hFC0 + 32'($urandom_range(0, 63));
    if ($urandom_range(0, 1) == 0) return 32'h1000 + 32'($urandom_range(0, 15));
    return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    sel = 0; req_v = 0; we_v = 0; uns_v = 0; size_v = 0; addr_v = 0; wdata_v = 0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst0_flags", 32'({if0.busy, if0.ack, if0.err}), 32'h0);
    chk("rst0_rdata", if0.rdata, 32'h0);
    chk("rst3_flags", 32'({if3.busy, if3.ack, if3.err}), 32'h0);
    chk("rst3_rdata", if3.rdata, 32'h0);
    rst0 = 1'b0; rst3 = 1'b0;

    // Zero-wait directed sequence
    sel = 0;
    txn(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, "sw10");
    txn(0, 2'b10, 0, 32'h10, 32'h0, 0, "lw10");
    chk("lw10_const", o_rdata, 32'hDEADBEEF);
    txn(0, 2'b00, 0, 32'h13, 32'h0, 0, "lb13");
    chk("lb13_const", o_rdata, 32'hFFFFFFDE);
    txn(0, 2'b00, 1, 32'h13, 32'h0, 0, "lbu13");
    chk("lbu13_const", o_rdata, 32'h000000DE);
    txn(0, 2'b01, 0, 32'h12, 32'h0, 0, "lh12");
    chk("lh12_const", o_rdata, 32'hFFFFDEAD);
    txn(1, 2'b00, 0, 32'h11, 32'h0000005A, 0, "sb11");
    txn(0, 2'b10, 0, 32'h10, 32'h0, 0, "lw10b");
    chk("lw10b_const", o_rdata, 32'hDEAD5AEF);
    txn(0, 2'b10, 0, 32'h12, 32'h0, 0, "lw12_mis");
    txn(1, 2'b10, 0, 32'hFFC, 32'h11223344, 0, "swFFC");
    txn(1, 2'b01, 0, 32'hFFF, 32'hAAAA, 0, "shFFF_oob");
    txn(0, 2'b00, 1, 32'hFFF, 32'h0, 0, "lbuFFF");
    chk("lbuFFF_const", o_rdata, 32'h00000011);
    txn(0, 2'b10, 0, 32'hFFC, 32'h0, 0, "lwFFC");
    txn(0, 2'b11, 0, 32'h20, 32'h0, 0, "lrsv");

    // Fill the random-test regions so every in-range load is predictable
    for (int i = 0; i < 64; i += 4) txn(1, 2'b10, 0, 32'(i), $urandom, 0, "init0_lo");
    for (int i = 32'hFC0; i < 32'h1000; i += 4) txn(1, 2'b10, 0, 32'(i), $urandom, 0, "init0_hi");
    for (int i = 0; i < 80; i++)
      txn(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(0), $urandom, 0, "rnd0");

    // Three wait states
    sel = 1;
    for (int i = 0; i < 64; i += 4) txn(1, 2'b10, 0, 32'(i), $urandom, 0, "init3");
    txn(0, 2'b10, 0, 32'h8, 32'h0, 1, "lw8_toggle");
    for (int i = 0; i < 20; i++)
      txn(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(1), $urandom, 1, "rnd3");

    // Reset during the wait of a store: abandoned, nothing written
    txn(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, "sw20_pre");
    txn(0, 2'b00, 0, 32'h21, 32'h0, 0, "lb21_pre");
    @(negedge clk);
    req_v = 1'b1; we_v = 1'b1; size_v = 2'b10; addr_v = 32'h20; wdata_v = 32'h12345678;
    @(negedge clk);
    chk("rst_mid_busy", 32'(o_flags), 32'(3'b100));
    req_v = 1'b0;
    #2 rst3 = 1'b1;
    #1;
    chk("rst_mid_flags", 32'(o_flags), 32'h0);
    chk("rst_mid_rdata", o_rdata, 32'h0);
    exp_rd[1] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    txn(0, 2'b10, 0, 32'h20, 32'h0, 0, "lw20_post");
    chk("lw20_post_const", o_rdata, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port.md
Name: mem_port

Overview:
- Parametrised, synchronous, byte-addressed data memory for the rv datapath.
- Successor to the single-cycle combinational 32-bit memory.
- Adds a req/ack handshake, configurable wait states, RISC-V byte/half/word access sizes with sign or zero extension, misalignment and range error reporting, and parametrised depth.
- Sits between the control unit / address bus and the shared data bus; control waits on ack before advancing.

Parameters:
- DEPTH_BYTES, 4096: storage size in bytes; must be a power of two and at least 4.
- ADDR_W, 32: width of the addr port.
- WAIT_STATES, 0: extra cycles inserted between accept and ack; range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  transaction request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- uns  input  1  load zero-extends when 1, sign-extends when 0; ignored for word and for stores.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data; low bytes used for sub-word stores.
- rdata  output  32  load result; valid in the ack cycle.
- ack  output  1  one-cycle pulse: transaction completed successfully.
- err  output  1  one-cycle pulse: transaction rejected.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst high):
  - State goes to IDLE.
  - ack, err and busy go to 0; rdata goes to 0.
  - Storage array is NOT cleared.
  - A transaction in flight is abandoned with no memory write.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at a rising edge, latch we, size, uns, addr and wdata.
  - If WAIT_STATES > 0, go to WAIT and load a counter with WAIT_STATES-1; otherwise go to RESP.
- WAIT: decrement the counter each cycle; at 0 go to RESP.
- RESP:
  - Exactly one of ack or err is high for this one cycle; then return to IDLE.
- Latency: req sampled at edge N gives ack/err high during the cycle after edge N+WAIT_STATES.
  - With WAIT_STATES=0, ack is visible the cycle immediately following acceptance.
- Error check, computed on latched values:
  - size=11 is an error.
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
  - addr + bytes - 1 ≥ DEPTH_BYTES is an error, tested on the full ADDR_W value with no wrap-around.
  - On error: err=1, ack=0, no write, rdata holds its previous value.
- Store: the write occurs at the edge that enters RESP. Bytes are little-endian.
  - Byte: mem[a] ← wdata[7:0].
  - Half: mem[a], mem[a+1] ← wdata[15:0].
  - Word: all four bytes.
- Load: the array is read at the edge entering RESP; rdata is registered.
  - Sub-word results are right-justified, then zero- or sign-extended per uns.
- rdata holds its value outside the ack cycle and is unchanged by stores.
- Handshake:
  - req, and changes to the other inputs, are ignored while busy=1.
  - If req is still high in the IDLE cycle after ack/err, a new transaction starts. The requester must drop req in the ack cycle to avoid a repeat.
  - Minimum of 2 cycles per transaction.
- Memory index uses addr[$clog2(DEPTH_BYTES)-1:0] only, after the range check passes.

Decomposition:
- Shared package rv_pkg holds:
  - enum mem_size_e (MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10).
  - The state enum for this block.
  - The function load_extend(word, size, uns, lane), reused later by the load/store unit.
- One sub-module, mem_array: a byte-lane storage array with four byte write enables and a registered 32-bit read. It has no reset.

Test Plan:
- WAIT_STATES=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> ack at N+1 each time; rdata=0xDEADBEEF.
- After the above, load byte at 0x13 with uns=0 -> rdata=0xFFFFFFDE. Same with uns=1 -> 0x000000DE. Load half at 0x12 with uns=0 -> 0xFFFFDEAD.
- Store byte 0x5A at 0x11, then load word at 0x10 -> 0xDEAD5AEF; other bytes unchanged.
- Load word at 0x12 -> err pulse, no ack. Store half at 0xFFF -> err, and byte 0xFFF unchanged. Load word at 0xFFC -> ack. Load with size=11 -> err.
- WAIT_STATES=3: accept at edge N -> busy high for 4 cycles, ack during cycle N+4. A req toggled while busy is ignored, giving exactly one ack.
- Assert rst during WAIT of a store to 0x20 -> ack, err and busy go to 0 immediately. A later load at 0x20 returns the pre-store value.
